otter_dmem_arbiter: RTL and testbench
=====================================

// Module: otter_dmem_arbiter
// PURPOSE
//   Two-master arbiter for the single data port of the unified OTTER memory.
//   Master 0 is the CPU load/store unit; master 1 is the DMA/debug master.
//   Registered round-robin grant (or fixed priority), address-range check,
//   single-cycle ack per access. Sits between the masters and the memory data port.
//   That port has 1-cycle synchronous read latency and byte-lane write selects.
// PARAMETERS
//   BRAM_BYTES  65536  memory size in bytes; byte addr >= BRAM_BYTES is out of range
//   RR_ENABLE   1      1 = round-robin between masters; 0 = master 0 always wins ties
// PORTS
//   i_clk          in   1   clock, all state on posedge
//   i_rst_n        in   1   asynchronous, active-low reset
//   i_mX_req       in   1   master X (X=0,1) access request, held until ack
//   i_mX_we        in   1   1 = write, 0 = read
//   i_mX_sel       in   4   byte-lane write enables (ignored for reads)
//   i_mX_addr      in   32  byte address
//   i_mX_wdata     in   32  write data
//   o_mX_ack       out  1   1-cycle pulse: access complete
//   o_mX_err       out  1   valid with ack: address out of range, memory untouched
//   o_mX_rdata     out  32  read data, valid only while o_mX_ack=1 on a read
//   o_mem_re       out  1   memory data-port read enable
//   o_mem_we       out  1   memory data-port write enable
//   o_mem_sel      out  4   memory byte-lane selects
//   o_mem_addr     out  32  memory byte address
//   o_mem_wdata    out  32  memory write data
//   i_mem_rdata    in   32  memory registered read data (1 cycle after o_mem_re)
// BEHAVIOUR
//   Reset (async, i_rst_n=0)
//     state=IDLE, last_grant=1, so master 0 wins the first tie.
//     All outputs 0; strobes decode from state, so they drop immediately.
//   FSM: IDLE -> ISSUE -> RESP -> IDLE. One access per 3 cycles; no pipelining.
//   IDLE
//     Sample the requests. If none: stay in IDLE.
//     If one: grant it. If both and RR_ENABLE=1: grant the master != last_grant.
//     If both and RR_ENABLE=0: grant master 0.
//     Register gnt and range flag (addr[31:0] >= BRAM_BYTES) -> ISSUE.
//   ISSUE
//     o_mem_addr/sel/wdata are muxed from the granted master's inputs.
//     In range: o_mem_re=~we, o_mem_we=we, o_mem_sel=sel (read: sel driven 0).
//     Out of range: re=we=0. Then -> RESP.
//   RESP
//     o_mgnt_ack=1. o_mgnt_err=range flag.
//     o_mgnt_rdata = i_mem_rdata for an in-range read, else 0. last_grant<=gnt.
//     -> IDLE. No memory strobe in RESP.
//   Non-granted master sees ack=0, err=0, rdata=0 at all times.
//   o_mem_* are 0 outside ISSUE.
//   Master protocol
//     Hold req/we/sel/addr/wdata stable from assertion until the ack cycle.
//     Req still high in the cycle after ack = new request.
//     Req dropped before ack (violation): the access still completes and acks.
//   Latency: req seen at edge N -> memory strobe in cycle N+1 -> ack in cycle N+2.
//   Under continuous contention with RR_ENABLE=1, grants strictly alternate.
//   Reset mid-access: aborts with no ack. A write in ISSUE may or may not commit.
//   Address bits above log2(BRAM_BYTES) are checked only for range.
//   The memory indexes addr[log2(BRAM_BYTES)-1:2].
// TESTING
//   1 Reset
//     Assert i_rst_n=0 mid-ISSUE -> all o_* = 0 in the same cycle.
//     Release, m0 & m1 req together -> m0 granted first.
//   2 Single read
//     m0 read addr 0x100, memory word 0xDEADBEEF -> o_mem_re=1 exactly 1 cycle.
//     Then o_m0_ack=1, o_m0_rdata=0xDEADBEEF, err=0.
//   3 Byte write
//     m1 write addr 0x204, sel=4'b0010, wdata=0x0000AB00 -> o_mem_we=1, sel=0010 one cycle.
//     Read back via m0 -> byte 1 = 0xAB, other bytes unchanged.
//   4 Contention
//     m0, m1 hold req for 4 accesses each -> acks alternate m0,m1,m0,m1...
//     Each ack 3 cycles apart. With RR_ENABLE=0: all m0 before any m1.
//   5 Out of range
//     m0 read addr 0x0001_0000 (BRAM_BYTES=65536) -> no o_mem_re/we.
//     o_m0_ack=1, o_m0_err=1, rdata=0.
//   6 Back-to-back
//     m0 keeps req high after ack with a new addr -> next ISSUE uses the new addr.
//     No idle gap beyond the IDLE cycle.

Source files
------------

// File: rtl/otter_dmem_arbiter.sv
// Two-master arbiter for the OTTER unified-memory data port.
// Three-phase handshake per access (IDLE/ISSUE/RESP), registered grant and range flag.
module otter_dmem_arbiter #(
  parameter int BRAM_BYTES = 65536,
  parameter bit RR_ENABLE  = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_m0_req,
  input  logic        i_m0_we,
  input  logic [3:0]  i_m0_sel,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m0_wdata,
  output logic        o_m0_ack,
  output logic        o_m0_err,
  output logic [31:0] o_m0_rdata,
  input  logic        i_m1_req,
  input  logic        i_m1_we,
  input  logic [3:0]  i_m1_sel,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_wdata,
  output logic        o_m1_ack,
  output logic        o_m1_err,
  output logic [31:0] o_m1_rdata,
  output logic        o_mem_re,
  output logic        o_mem_we,
  output logic [3:0]  o_mem_sel,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata
);

  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_ISSUE = 2'd1;
  localparam logic [1:0]  ST_RESP  = 2'd2;
  localparam logic [31:0] ADDR_LIMIT = 32'(BRAM_BYTES);

  logic [1:0] state_reg;
  logic       gnt_reg;
  logic       oor_reg;
  logic       we_reg;
  logic       last_grant_reg;

  logic        any_req;
  logic        grant_next;
  logic [31:0] cand_addr;
  logic        cand_we;

  logic        in_issue;
  logic        in_resp;
  logic        g_we;
  logic [3:0]  g_sel;
  logic [31:0] g_addr;
  logic [31:0] g_wdata;
  logic        rd_ok;

  // Tie-break: round-robin favours the master that did not win last time.
  always_comb begin
    any_req    = i_m0_req | i_m1_req;
    grant_next = 1'b0;
    if (i_m0_req && i_m1_req) begin
      grant_next = RR_ENABLE ? ~last_grant_reg : 1'b0;
    end else if (i_m1_req) begin
      grant_next = 1'b1;
    end
    cand_addr = grant_next ? i_m1_addr : i_m0_addr;
    cand_we   = grant_next ? i_m1_we   : i_m0_we;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg      <= ST_IDLE;
      gnt_reg        <= 1'b0;
      oor_reg        <= 1'b0;
      we_reg         <= 1'b0;
      last_grant_reg <= 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (any_req) begin
            gnt_reg   <= grant_next;
            oor_reg   <= (cand_addr >= ADDR_LIMIT);
            we_reg    <= cand_we;
            state_reg <= ST_ISSUE;
          end
        end
        ST_ISSUE: state_reg <= ST_RESP;
        ST_RESP: begin
          last_grant_reg <= gnt_reg;
          state_reg      <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode straight from state so an async reset clears them at once.
  always_comb begin
    in_issue = (state_reg == ST_ISSUE);
    in_resp  = (state_reg == ST_RESP);
    g_we     = we_reg;
    g_sel    = gnt_reg ? i_m1_sel   : i_m0_sel;
    g_addr   = gnt_reg ? i_m1_addr  : i_m0_addr;
    g_wdata  = gnt_reg ? i_m1_wdata : i_m0_wdata;

    o_mem_re    = in_issue & ~oor_reg & ~g_we;
    o_mem_we    = in_issue & ~oor_reg & g_we;
    o_mem_sel   = o_mem_we ? g_sel : 4'b0000;
    o_mem_addr  = in_issue ? g_addr : 32'h0;
    o_mem_wdata = in_issue ? g_wdata : 32'h0;

    rd_ok      = in_resp & ~oor_reg & ~we_reg;
    o_m0_ack   = in_resp & ~gnt_reg;
    o_m1_ack   = in_resp & gnt_reg;
    o_m0_err   = o_m0_ack & oor_reg;
    o_m1_err   = o_m1_ack & oor_reg;
    o_m0_rdata = (rd_ok && !gnt_reg) ? i_mem_rdata : 32'h0;
    o_m1_rdata = (rd_ok && gnt_reg)  ? i_mem_rdata : 32'h0;
  end

endmodule

// File: tb/tb_otter_dmem_arbiter.sv
// Directed bench for otter_dmem_arbiter: a round-robin instance with a memory model
// and a fixed-priority instance sharing the master inputs.
module tb_otter_dmem_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [3:0]  m0_sel = 0, m1_sel = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_re, mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        f0_ack, f0_err, f1_ack, f1_err, f_re, f_we;
  logic [31:0] f0_rdata, f1_rdata, f_addr, f_wdata;
  logic [3:0]  f_sel;

  int checks = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  otter_dmem_arbiter #(.BRAM_BYTES(65536), .RR_ENABLE(1'b1)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_sel(m0_sel), .i_m0_addr(m0_addr),
    .i_m0_wdata(m0_wdata), .o_m0_ack(m0_ack), .o_m0_err(m0_err), .o_m0_rdata(m0_rdata),
    .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_sel(m1_sel), .i_m1_addr(m1_addr),
    .i_m1_wdata(m1_wdata), .o_m1_ack(m1_ack), .o_m1_err(m1_err), .o_m1_rdata(m1_rdata),
    .o_mem_re(mem_re), .o_mem_we(mem_we), .o_mem_sel(mem_sel), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  otter_dmem_arbiter #(.BRAM_BYTES(65536), .RR_ENABLE(1'b0)) dut_fp (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_sel(m0_sel), .i_m0_addr(m0_addr),
    .i_m0_wdata(m0_wdata), .o_m0_ack(f0_ack), .o_m0_err(f0_err), .o_m0_rdata(f0_rdata),
    .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_sel(m1_sel), .i_m1_addr(m1_addr),
    .i_m1_wdata(m1_wdata), .o_m1_ack(f1_ack), .o_m1_err(f1_err), .o_m1_rdata(f1_rdata),
    .o_mem_re(f_re), .o_mem_we(f_we), .o_mem_sel(f_sel), .o_mem_addr(f_addr),
    .o_mem_wdata(f_wdata), .i_mem_rdata(32'h0)
  );

  // Memory model: registered read, byte-lane writes, word index addr[15:2].
  logic [31:0] mem [0:16383];
  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    mem[14'h040] = 32'hDEADBEEF;
    mem[14'h081] = 32'h11223344;
    mem_rdata = 32'h0;
  end
  always @(posedge i_clk) begin
    if (mem_re) mem_rdata <= mem[mem_addr[15:2]];
    if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_sel[b]) mem[mem_addr[15:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return {24'h0, m0_ack | m0_err | m1_ack | m1_err | mem_re | mem_we | f_re | f_we,
            (|m0_rdata) | (|m1_rdata) | (|mem_addr) | (|mem_wdata) | (|mem_sel),
            (|f_addr) | (|f_wdata) | (|f_sel) | f0_ack | f1_ack, 5'b0};
  endfunction

  task automatic drive(input int m, input logic req, input logic we, input logic [3:0] sel,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (m == 0) begin
      m0_req = req; m0_we = we; m0_sel = sel; m0_addr = addr; m0_wdata = wdata;
    end else begin
      m1_req = req; m1_we = we; m1_sel = sel; m1_addr = addr; m1_wdata = wdata;
    end
  endtask

  // Single access from an idle arbiter; ack expected on the second cycle after request.
  task automatic do_access(input string tag, input int m, input logic we, input logic [3:0] sel,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input logic exp_err);
    int re_cnt = 0;
    int we_cnt = 0;
    int ack_cyc = -1;
    drive(m, 1'b1, we, sel, addr, wdata);
    for (int cyc = 0; cyc < 8 && ack_cyc < 0; cyc++) begin
      step();
      if (mem_re) re_cnt++;
      if (mem_we) begin
        we_cnt++;
        check({tag, "_sel"}, {28'h0, mem_sel}, {28'h0, sel});
        check({tag, "_wdata"}, mem_wdata, wdata);
      end
      if (mem_re || mem_we) check({tag, "_addr"}, mem_addr, addr);
      if ((m == 0) ? m0_ack : m1_ack) begin
        ack_cyc = cyc;
        check({tag, "_rdata"}, (m == 0) ? m0_rdata : m1_rdata, exp_rdata);
        check({tag, "_err"}, {31'h0, (m == 0) ? m0_err : m1_err}, {31'h0, exp_err});
        check({tag, "_other_ack"}, {31'h0, (m == 0) ? m1_ack : m0_ack}, 32'h0);
      end
    end
    check({tag, "_ack_latency"}, ack_cyc, 32'd1);
    check({tag, "_re_cycles"}, re_cnt, (!we && !exp_err) ? 32'd1 : 32'd0);
    check({tag, "_we_cycles"}, we_cnt, (we && !exp_err) ? 32'd1 : 32'd0);
    drive(m, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();
    $display("access %s m%0d we=%0d addr=0x%08h ack_cyc=%0d", tag, m, we, addr, ack_cyc);
  endtask

  initial begin
    int first_m;
    int prev_m;
    int prev_cyc;
    int rr_acks;
    int f0_cnt;
    int f1_cnt;
    int seen;

    // Reset state
    #1;
    check("reset_outs", all_outs(), 32'h0);
    step(); step();
    i_rst_n = 1'b1;
    step();

    // Reset in the middle of ISSUE
    drive(0, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
    step();
    check("pre_reset_re", {31'h0, mem_re}, 32'h1);
    i_rst_n = 1'b0;
    #1;
    check("midissue_reset_outs", all_outs(), 32'h0);
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();
    check("held_reset_outs", all_outs(), 32'h0);
    i_rst_n = 1'b1;
    step();

    // First tie after reset goes to master 0, then master 1
    drive(0, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
    drive(1, 1'b1, 1'b0, 4'h0, 32'h204, 32'h0);
    first_m = -1;
    for (int c = 0; c < 8 && first_m < 0; c++) begin
      step();
      if (m0_ack) first_m = 0;
      else if (m1_ack) first_m = 1;
    end
    check("first_tie_winner", first_m, 32'd0);
    check("first_tie_rdata", m0_rdata, 32'hDEADBEEF);
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    seen = 0;
    for (int c = 0; c < 8 && seen == 0; c++) begin
      step();
      if (m1_ack) begin
        seen = 1;
        check("tie_m1_rdata", m1_rdata, 32'h11223344);
      end
    end
    check("tie_m1_served", seen, 32'd1);
    drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();
    $display("reset/tie first=m%0d m1_served=%0d", first_m, seen);

    // Single read, byte write, readback, out of range
    do_access("read100", 0, 1'b0, 4'hF, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0);
    do_access("bytewr", 1, 1'b1, 4'b0010, 32'h204, 32'h0000AB00, 32'h0, 1'b0);
    do_access("readback", 0, 1'b0, 4'h0, 32'h204, 32'h0, 32'h1122AB44, 1'b0);
    do_access("oor_read", 0, 1'b0, 4'h0, 32'h0001_0000, 32'h0, 32'h0, 1'b1);
    do_access("oor_write", 1, 1'b1, 4'hF, 32'h8000_0100, 32'hFFFFFFFF, 32'h0, 1'b1);
    do_access("read100_after", 1, 1'b0, 4'h0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0);

    // Back-to-back: keep req high with a new address at the ack
    drive(0, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
    step();
    step();
    check("b2b_ack1", {31'h0, m0_ack}, 32'h1);
    m0_addr = 32'h204;
    step();
    check("b2b_idle_gap", {31'h0, mem_re}, 32'h0);
    step();
    check("b2b_issue_re", {31'h0, mem_re}, 32'h1);
    check("b2b_issue_addr", mem_addr, 32'h204);
    step();
    check("b2b_ack2", {31'h0, m0_ack}, 32'h1);
    check("b2b_rdata2", m0_rdata, 32'h1122AB44);
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();
    $display("back-to-back second addr=0x204 rdata=0x%08h", mem[14'h081]);

    // Contention: both hold req; RR alternates, fixed priority starves m1
    drive(0, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
    drive(1, 1'b1, 1'b0, 4'h0, 32'h204, 32'h0);
    prev_m = -1; prev_cyc = -1; rr_acks = 0; f0_cnt = 0; f1_cnt = 0;
    for (int c = 0; c < 24; c++) begin
      step();
      if (f0_ack) f0_cnt++;
      if (f1_ack) f1_cnt++;
      if (m0_ack || m1_ack) begin
        int cur_m;
        cur_m = m1_ack ? 1 : 0;
        check("rr_single_ack", {31'h0, m0_ack & m1_ack}, 32'h0);
        if (prev_m >= 0) begin
          check("rr_alternate", cur_m, 1 - prev_m);
          check("rr_spacing", c - prev_cyc, 32'd3);
        end
        check("rr_rdata", cur_m ? m1_rdata : m0_rdata, cur_m ? 32'h1122AB44 : 32'hDEADBEEF);
        $display("contend cyc=%0d ack m%0d", c, cur_m);
        prev_m = cur_m;
        prev_cyc = c;
        rr_acks++;
      end
    end
    check("rr_ack_count", rr_acks, 32'd8);
    check("fp_m0_count", f0_cnt, 32'd8);
    check("fp_m1_starved", f1_cnt, 32'd0);
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      step();
      if (f1_ack) seen = 1;
    end
    check("fp_m1_after_m0", seen, 32'd1);
    drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step(); step(); step(); step();
    check("final_idle_outs", all_outs(), 32'h0);
    $display("fixed-priority m0=%0d m1_during=%0d m1_after=%0d", f0_cnt, f1_cnt, seen);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
